ext_llr_pipe: RTL and testbench
===============================

Name: ext_llr_pipe

Overview:
- Parametrised, pipelined successor to the 8-state max-log-MAP extrinsic stage of the turbo decoder SISO.
- Per trellis step, takes forward metrics (alpha), backward metrics (beta), the four branch metrics and the systematic LLR, and produces the saturated, scaled extrinsic LLR.
- Adds valid/ready flow control, block framing, a saturation counter, a selectable extrinsic scale and optional log-MAP correction.
- Sits between the alpha/beta memories and the interleaver write port.

Parameters:
- W, 16, metric/LLR width (signed two's complement), legal 8..24
- CNT_W, 16, width of saturation counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input step valid
- in_ready  out  1  block can accept step
- in_last  in  1  last step of code block
- in_scale  in  2  extrinsic scale: 00 x1, 01 x0.75, 10 x0.5, 11 x0.875
- alpha  in  8*W  alpha[s] = bits [s*W +: W], s=0..7
- beta  in  8*W  beta[s], same packing
- m00, m01, m10, m11  in  W each  branch metrics
- systematic  in  W  systematic LLR
- out_valid  out  1  ext valid
- out_ready  in  1  downstream accepts
- out_ext  out  W  extrinsic LLR
- out_last  out  1  in_last aligned with out_ext
- sat_cnt  out  CNT_W  saturated outputs in current block

Behaviour:
- Arithmetic is signed throughout.
- SAT() clamps to [-(2^(W-1)-1), +(2^(W-1)-1)]. The most negative code never appears on any register or output.
- Sums are formed at W+2 bits before SAT.
- Stage 1 registers 16 path sums SAT(alpha+beta):
  - g00: (a0,b0) (a1,b4) (a6,b7) (a7,b3)
  - g01: (a2,b5) (a3,b1) (a4,b2) (a5,b6)
  - g11: (a0,b4) (a1,b0) (a6,b3) (a7,b7)
  - g10: (a2,b1) (a3,b5) (a4,b6) (a5,b2)
  - Also registers branch metrics, systematic, scale and last.
- Stage 2 registers two values:
  - L0 = MAXF(SAT(max(g00)+m00), SAT(max(g01)+m01))
  - L1 = MAXF(SAT(max(g11)+m11), SAT(max(g10)+m10))
  - max over a group is a 4-to-1 signed max tree.
  - MAXF is plain signed max, or max* when the optional feature is enabled.
- Stage 3 computes e = SAT(L1 - SAT(L0 + systematic)), then applies the scale with arithmetic right shift (floor):
  - x1: e
  - x0.75: e - (e>>>2)
  - x0.5: e>>>1
  - x0.875: e - (e>>>3)
  - The scaled result is registered to out_ext.
- Flow control:
  - advance = out_ready | ~out_valid, and in_ready = advance.
  - All three stages and their valid bits shift together only when advance=1.
  - Bubbles occupy stages. Registers hold while stalled.
- Latency is 3 cycles from accepted input to out_valid with out_ready held high. Throughput is 1 step/cycle.
- Payload is undefined while out_valid=0. out_ext and out_last are stable while out_valid=1 and out_ready=0.
- sat_cnt:
  - Increments (saturating at all-ones) on each accepted output (out_valid & out_ready) where any SAT in that step's path clamped. The per-stage sticky flag is carried down the pipe.
  - The first accepted output after an accepted output with out_last=1 resets the count to 0 or 1 before counting, so the count restarts per block.
- Reset: all valid bits 0, out_ext 0, out_last 0, sat_cnt 0. in_ready is 1 immediately after reset deassertion. Reset mid-block discards in-flight steps with no partial output.
- in_scale and in_last are sampled per step, so scale can change step-to-step.

Optional Feature:
- Macro: LOGMAP_CORR_EN
- Defined: MAXF(x,y) = max(x,y) + c(|x-y|), then SAT. Metrics are in Q.3 format. c(d) is:
  - d 0..1 → 5
  - d 2..3 → 4
  - d 4..5 → 3
  - d 6..8 → 2
  - d 9..13 → 1
  - d ≥14 → 0
  - |x-y| is computed at W+1 bits.
- Undefined: MAXF = plain signed max (max-log-MAP). No LUT logic is synthesised.

Test Plan:
- Zero metrics: all alpha/beta/m00/m01/m10 = 0, m11 = 100, sys = 0, scale = 00, feature off → out_ext = 100 exactly 3 cycles after acceptance; sat_cnt = 0.
- Saturation: alpha0 = beta4 = 0x7FFF, others 0, sys = 0x8001, m* = 0 → out_ext = 0x7FFF, sat_cnt = 1.
- Scale: ext pre-scale 100 with scale 01 → 75; pre-scale -101 with scale 01 → -75; -101 with scale 10 → -51.
- Backpressure: stream 10 steps, out_ready low for cycles 4-7 → in_ready low for the same cycles, no loss or duplication, order preserved, out_ext held while stalled.
- Block framing: block of 4 steps with two saturating, then a new block → sat_cnt = 2 at that block's out_last, restarts at the next block; reset asserted mid-stream → out_valid = 0 next edge, sat_cnt = 0.
- LOGMAP_CORR_EN defined, L0 branch inputs equal (both 40) → L0 = 45; with macro undefined → 40.

Source files
------------

// File: rtl/ext_llr_pipe_if.sv
// Step/extrinsic stream bundle for ext_llr_pipe: input step handshake, output
// extrinsic handshake and the per-block saturation count.
interface ext_llr_pipe_if #(
  parameter int W     = 16,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [1:0]       in_scale;
  logic [8*W-1:0]   alpha;
  logic [8*W-1:0]   beta;
  logic [W-1:0]     m00, m01, m10, m11;
  logic [W-1:0]     systematic;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_ext;
  logic             out_last;
  logic [CNT_W-1:0] sat_cnt;

  modport master (
    output in_valid, in_last, in_scale, alpha, beta, m00, m01, m10, m11, systematic, out_ready,
    input  in_ready, out_valid, out_ext, out_last, sat_cnt
  );

  modport slave (
    input  in_valid, in_last, in_scale, alpha, beta, m00, m01, m10, m11, systematic, out_ready,
    output in_ready, out_valid, out_ext, out_last, sat_cnt
  );
endinterface

// File: rtl/ext_llr_pipe.sv
// 3-stage max-log-MAP extrinsic LLR pipeline with valid/ready, block framing and
// saturation counting. Define LOGMAP_CORR_EN to add the log-MAP max* correction.
module ext_llr_pipe #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input logic           clk,
  input logic           rst_n,
  ext_llr_pipe_if.slave llr
);
  localparam int SW = W + 2;
  localparam logic signed [SW-1:0] MAXV = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = -MAXV;

  // Groups: 0=g00, 1=g01, 2=g11, 3=g10; (alpha, beta) state pairs per group.
  localparam int PA [4][4] = '{'{0, 1, 6, 7}, '{2, 3, 4, 5}, '{0, 1, 6, 7}, '{2, 3, 4, 5}};
  localparam int PB [4][4] = '{'{0, 4, 7, 3}, '{5, 1, 2, 6}, '{4, 0, 3, 7}, '{1, 5, 6, 2}};

  function automatic logic signed [SW-1:0] sx(input logic [W-1:0] v);
    return SW'($signed(v));
  endfunction

  function automatic logic clip(input logic signed [SW-1:0] x);
    return (x > MAXV) || (x < MINV);
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] y;
    y = (x > MAXV) ? MAXV : ((x < MINV) ? MINV : x);
    return y[W-1:0];
  endfunction

  function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  function automatic logic signed [SW-1:0] maxf(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef LOGMAP_CORR_EN
    logic signed [W:0] df;
    logic [W:0]        d;
    logic [2:0]        c;
    df = (W+1)'($signed(x)) - (W+1)'($signed(y));
    d  = df[W] ? (W+1)'(-df) : df;
    // Q.3 approximation of ln(1 + exp(-d))
    if      (d <= (W+1)'(1))  c = 3'd5;
    else if (d <= (W+1)'(3))  c = 3'd4;
    else if (d <= (W+1)'(5))  c = 3'd3;
    else if (d <= (W+1)'(8))  c = 3'd2;
    else if (d <= (W+1)'(13)) c = 3'd1;
    else                      c = 3'd0;
    return sx(smax(x, y)) + $signed(SW'(c));
`else
    return sx(smax(x, y));
`endif
  endfunction

  logic       adv;
  logic [3:1] vld_q;

  // Stage 1
  logic [3:0][3:0][W-1:0] g_d, g_q;
  logic [3:0][W-1:0]      m_d, m_q;   // m00, m01, m11, m10 (group order)
  logic [W-1:0]           sys1_d, sys1_q;
  logic [1:0]             scale1_q;
  logic                   last1_q, sat1_d, sat1_q;
  // Stage 2
  logic [W-1:0]           l0_d, l0_q, l1_d, l1_q, sys2_q;
  logic [1:0]             scale2_q;
  logic                   last2_q, sat2_d, sat2_q;
  // Stage 3
  logic [W-1:0]           ext_d, ext_q;
  logic                   last3_q, sat3_d, sat3_q;
  // Block-level saturation count
  logic [CNT_W-1:0]       cnt_d, cnt_q, cnt_base;
  logic                   blk_end_d, blk_end_q;

  assign adv           = llr.out_ready | ~vld_q[3];
  assign llr.in_ready  = adv;
  assign llr.out_valid = vld_q[3];
  assign llr.out_ext   = ext_q;
  assign llr.out_last  = last3_q;
  assign llr.sat_cnt   = cnt_q;

  always_comb begin
    logic signed [SW-1:0] sum;
    logic [3:0][W-1:0]    min_br;
    sum    = '0;
    g_d    = '0;
    m_d    = '0;
    sat1_d = 1'b0;
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) begin
        sum       = sx(llr.alpha[PA[g][k]*W +: W]) + sx(llr.beta[PB[g][k]*W +: W]);
        g_d[g][k] = sat(sum);
        sat1_d    = sat1_d | clip(sum);
      end
    end
    // Raw inputs pass through SAT too so the most negative code never gets registered
    min_br = {llr.m10, llr.m11, llr.m01, llr.m00};
    for (int i = 0; i < 4; i++) begin
      m_d[i] = sat(sx(min_br[i]));
      sat1_d = sat1_d | clip(sx(min_br[i]));
    end
    sys1_d = sat(sx(llr.systematic));
    sat1_d = sat1_d | clip(sx(llr.systematic));
  end

  always_comb begin
    logic [3:0][W-1:0]    br;
    logic [W-1:0]         mx;
    logic signed [SW-1:0] s;
    br     = '0;
    mx     = '0;
    s      = '0;
    sat2_d = sat1_q;
    for (int g = 0; g < 4; g++) begin
      mx     = smax(smax(g_q[g][0], g_q[g][1]), smax(g_q[g][2], g_q[g][3]));
      s      = sx(mx) + sx(m_q[g]);
      br[g]  = sat(s);
      sat2_d = sat2_d | clip(s);
    end
    s      = maxf(br[0], br[1]);
    l0_d   = sat(s);
    sat2_d = sat2_d | clip(s);
    s      = maxf(br[2], br[3]);
    l1_d   = sat(s);
    sat2_d = sat2_d | clip(s);
  end

  always_comb begin
    logic signed [SW-1:0] s;
    logic [W-1:0]         t;
    logic signed [W-1:0]  e;
    s      = sx(l0_q) + sx(sys2_q);
    t      = sat(s);
    sat3_d = sat2_q | clip(s);
    s      = sx(l1_q) - sx(t);
    e      = $signed(sat(s));
    sat3_d = sat3_d | clip(s);
    case (scale2_q)
      2'b00:   ext_d = e;
      2'b01:   ext_d = e - (e >>> 2);
      2'b10:   ext_d = e >>> 1;
      default: ext_d = e - (e >>> 3);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      g_q      <= '0;
      m_q      <= '0;
      sys1_q   <= '0;
      scale1_q <= '0;
      last1_q  <= 1'b0;
      sat1_q   <= 1'b0;
      l0_q     <= '0;
      l1_q     <= '0;
      sys2_q   <= '0;
      scale2_q <= '0;
      last2_q  <= 1'b0;
      sat2_q   <= 1'b0;
      ext_q    <= '0;
      last3_q  <= 1'b0;
      sat3_q   <= 1'b0;
    end else if (adv) begin
      vld_q    <= {vld_q[2:1], llr.in_valid};
      g_q      <= g_d;
      m_q      <= m_d;
      sys1_q   <= sys1_d;
      scale1_q <= llr.in_scale;
      last1_q  <= llr.in_last;
      sat1_q   <= sat1_d;
      l0_q     <= l0_d;
      l1_q     <= l1_d;
      sys2_q   <= sys1_q;
      scale2_q <= scale1_q;
      last2_q  <= last1_q;
      sat2_q   <= sat2_d;
      ext_q    <= ext_d;
      last3_q  <= last2_q;
      sat3_q   <= sat3_d;
    end
  end

  // Count restarts on the first accepted output following an accepted out_last.
  always_comb begin
    cnt_d     = cnt_q;
    blk_end_d = blk_end_q;
    cnt_base  = blk_end_q ? '0 : cnt_q;
    if (vld_q[3] && llr.out_ready) begin
      cnt_d     = (sat3_q && (cnt_base != '1)) ? cnt_base + CNT_W'(1) : cnt_base;
      blk_end_d = last3_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      blk_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      blk_end_q <= blk_end_d;
    end
  end
endmodule

// File: tb/tb_ext_llr_pipe.sv
// Directed table-driven bench for ext_llr_pipe plus backpressure, framing and reset sequences.
module tb_ext_llr_pipe;
  localparam int W     = 16;
  localparam int CNT_W = 16;
`ifdef LOGMAP_CORR_EN
  localparam bit LM = 1'b1;
`else
  localparam bit LM = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ext_llr_pipe_if #(.W(W), .CNT_W(CNT_W)) bus ();
  ext_llr_pipe #(.W(W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .llr(bus));

  typedef struct {
    string          name;
    logic [8*W-1:0] alpha, beta;
    logic [W-1:0]   m00, m01, m10, m11, sys;
    logic [1:0]     scale;
    logic           last;
    logic [W-1:0]   ex;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t z(input string nm);
    vec_t v;
    v.name = nm; v.alpha = '0; v.beta = '0;
    v.m00 = '0; v.m01 = '0; v.m10 = '0; v.m11 = '0; v.sys = '0;
    v.scale = 2'b00; v.last = 1'b0; v.ex = '0; v.cnt = '0;
    return v;
  endfunction

  function automatic vec_t sat_step();
    vec_t v;
    v = z("sat");
    v.alpha[0*W +: W] = W'(16'h7FFF);
    v.beta[4*W +: W]  = W'(16'h7FFF);
    v.sys = W'(16'h8001);
    return v;
  endfunction

  function automatic vec_t plain_step(input int val);
    vec_t v;
    v = z("plain");
    v.m11 = W'(val); v.m01 = W'(-100); v.m10 = W'(-100);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.alpha = v.alpha; bus.beta = v.beta;
    bus.m00 = v.m00; bus.m01 = v.m01; bus.m10 = v.m10; bus.m11 = v.m11;
    bus.systematic = v.sys; bus.in_scale = v.scale; bus.in_last = v.last;
  endtask

  initial begin
    vec_t vt[10];
    vec_t fr[6];
    logic [CNT_W-1:0] fr_cnt[6];
    int sent, rcv, seen, lat;

    vt[0] = z("zero");      vt[0].m11 = W'(100); vt[0].ex = LM ? W'(95) : W'(100);
    vt[1] = sat_step();     vt[1].name = "satpos"; vt[1].ex = W'(16'h7FFF);
    vt[2] = z("x075pos");   vt[2].m11 = W'(100); vt[2].m01 = W'(-100); vt[2].scale = 2'b01; vt[2].ex = W'(75);
    vt[3] = z("x075neg");   vt[3].m00 = W'(101); vt[3].m10 = W'(-100); vt[3].scale = 2'b01; vt[3].ex = W'(-75);
    vt[4] = vt[3];          vt[4].name = "x05neg"; vt[4].scale = 2'b10; vt[4].ex = W'(-51);
    vt[5] = vt[2];          vt[5].name = "x0875last"; vt[5].scale = 2'b11; vt[5].last = 1'b1; vt[5].ex = W'(88);
    vt[6] = z("mixed");
    for (int s = 0; s < 8; s++) begin
      vt[6].alpha[s*W +: W] = W'(10*s);
      vt[6].beta[s*W +: W]  = W'(s);
    end
    vt[6].m00 = W'(5); vt[6].m01 = W'(30); vt[6].m11 = W'(-10); vt[6].m10 = W'(20);
    vt[6].sys = W'(7); vt[6].ex = LM ? W'(-20) : W'(-21);
    vt[7] = z("satneg");    vt[7].m11 = W'(-30000); vt[7].m10 = W'(-30000); vt[7].sys = W'(30000);
    vt[7].ex = W'(16'h8001);
    vt[8] = z("sysmin");    vt[8].sys = W'(16'h8000); vt[8].ex = W'(16'h7FFF);
    vt[9] = z("l0equal");   vt[9].m00 = W'(40); vt[9].m01 = W'(40); vt[9].m10 = W'(-100);
    vt[9].ex = LM ? W'(-45) : W'(-40);
    vt[0].cnt = 0; vt[1].cnt = 1; vt[2].cnt = 1; vt[3].cnt = 1; vt[4].cnt = 1;
    vt[5].cnt = 1; vt[6].cnt = 0; vt[7].cnt = 1; vt[8].cnt = 2; vt[9].cnt = 2;

    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive(z("idle"));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset out_valid", bus.out_valid, 1'b0);
    chk("reset out_ext", bus.out_ext, '0);
    chk("reset out_last", bus.out_last, 1'b0);
    chk("reset sat_cnt", bus.sat_cnt, '0);
    chk("reset in_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < 10; i++) begin
      drive(vt[i]);
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
        tick();
        lat++;
      end
      chk({vt[i].name, " latency"}, lat, 3);
      chk({vt[i].name, " out_ext"}, bus.out_ext, vt[i].ex);
      chk({vt[i].name, " out_last"}, bus.out_last, vt[i].last);
      tick();
      chk({vt[i].name, " sat_cnt"}, bus.sat_cnt, vt[i].cnt);
    end

    // Backpressure: out_ready low in cycles 4..7 of a 10-step stream
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 7);
      if (sent < 10) begin
        drive(plain_step(10 * (sent + 1)));
        bus.in_last  = (sent == 9);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (cyc < 12) chk("bp in_ready", bus.in_ready, !(cyc >= 4 && cyc <= 7));
      if (bus.out_valid) begin
        chk("bp out_ext", bus.out_ext, W'(10 * (rcv + 1)));
        chk("bp out_last", bus.out_last, rcv == 9);
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.out_valid && bus.out_ready) rcv++;
      tick();
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    chk("bp sent", sent, 10);
    chk("bp received", rcv, 10);

    // Framing: 4-step block (steps 1,2 saturate) then a block starting with a saturating step
    fr[0] = plain_step(50); fr[1] = sat_step(); fr[2] = sat_step();
    fr[3] = plain_step(50); fr[3].last = 1'b1;
    fr[4] = sat_step();     fr[5] = plain_step(50);
    fr_cnt[0] = 0; fr_cnt[1] = 1; fr_cnt[2] = 2; fr_cnt[3] = 2; fr_cnt[4] = 1; fr_cnt[5] = 1;
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      logic acc;
      if (sent < 6) begin
        drive(fr[sent]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      acc = bus.out_valid;
      if (acc) chk("frame out_last", bus.out_last, rcv == 3);
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
      if (acc) begin
        chk("frame sat_cnt", bus.sat_cnt, fr_cnt[rcv]);
        rcv++;
      end
    end
    bus.in_valid = 1'b0;
    chk("frame received", rcv, 6);

    // Reset with steps in flight: no output may emerge afterwards
    drive(sat_step());
    bus.in_valid = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst out_valid", bus.out_valid, 1'b0);
    chk("midrst sat_cnt", bus.sat_cnt, '0);
    chk("midrst out_ext", bus.out_ext, '0);
    tick();
    chk("midrst out_valid edge", bus.out_valid, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("midrst in_ready", bus.in_ready, 1'b1);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("midrst no partial output", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
